// File: rtl/stack_rr_arbiter.sv
// Shared LIFO scratch stack with round-robin access for NREQ requesters.
// One push or pop per IDLE -> EXEC -> ACK transaction, with a one-cycle ack and error flag.
module stack_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          op,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          ack,
  output logic [WIDTH-1:0]         rdata,
  output logic                     err,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     gnt_q;
  logic              op_q;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  rdata_q;
  logic [CW-1:0]     count_q;
  logic [NREQ-1:0]   ack_q;
  logic              err_q;

  logic [IW-1:0]     ptr_d;
  logic              win_vld;
  logic [IW-1:0]     win_idx;
  logic              can_push;
  logic              can_pop;
  logic              mem_we;
  logic [CW-1:0]     cnt_m1;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
  end

  // First requester found scanning upward from ptr, wrapping modulo NREQ.
  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld && req[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  assign ptr_d    = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
  assign can_push = (count_q < CW'(DEPTH));
  assign can_pop  = (count_q != '0);
  assign cnt_m1   = count_q - CW'(1);
  assign wr_addr  = count_q[AW-1:0];
  assign rd_addr  = cnt_m1[AW-1:0];
  // A flush during EXEC takes precedence over the pending push.
  assign mem_we   = (state_q == EXEC) && !clr && !op_q && can_push;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
      count_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          err_q <= 1'b0;
          if (clr) count_q <= '0;
          if (win_vld) begin
            gnt_q   <= win_idx;
            op_q    <= op[win_idx];
            data_q  <= wdata_arr[win_idx];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          state_q <= ACK;
          ptr_q   <= ptr_d;
          ack_q   <= NREQ'(1) << gnt_q;
          if (clr) begin
            count_q <= '0;
            err_q   <= 1'b1;
          end else if (!op_q) begin
            if (can_push) begin
              count_q <= count_q + CW'(1);
              err_q   <= 1'b0;
            end else begin
              err_q   <= 1'b1;
            end
          end else begin
            if (can_pop) begin
              rdata_q <= mem[rd_addr];
              count_q <= cnt_m1;
              err_q   <= 1'b0;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end
        ACK: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          if (clr) count_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign gnt_id = gnt_q;
  assign busy   = (state_q != IDLE);
  assign count  = count_q;
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

endmodule

// File: tb/tb_stack_rr_arbiter.sv
// Randomized bench for stack_rr_arbiter against a transaction-level model:
// a queue as the stack, an integer round-robin pointer and the last popped value.
module tb_stack_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  localparam int IW    = $clog2(NREQ);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                   clk;
  logic                   rstn;
  logic                   clr;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        op;
  logic [NREQ*WIDTH-1:0]  wdata;
  logic [NREQ-1:0]        ack;
  logic [WIDTH-1:0]       rdata;
  logic                   err;
  logic [IW-1:0]          gnt_id;
  logic                   busy;
  logic                   full;
  logic                   empty;
  logic [CW-1:0]          count;

  stack_rr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .req(req), .op(op), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .gnt_id(gnt_id), .busy(busy),
    .full(full), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [WIDTH-1:0] stk[$];
  int               m_ptr;
  logic [WIDTH-1:0] m_rdata;
  logic             pend  [NREQ];
  logic             pop_r [NREQ];
  logic [WIDTH-1:0] dat_r [NREQ];
  int               last_w;
  int               ack_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = pend[i];
      op[i]  = pop_r[i];
      wdata[i*WIDTH +: WIDTH] = dat_r[i];
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; pop_r[i] = 1'b0; dat_r[i] = '0;
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0; clr = 1'b0;
    clear_pend(); drive_req();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ack", ack, 0);
    check_val("rst_err", err, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_gnt", gnt_id, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_count", count, 0);
    check_val("rst_empty", empty, 1);
    stk.delete(); m_ptr = 0; m_rdata = '0;
    rstn = 1'b1;
  endtask

  // One arbitration slot. Entered #1 after a posedge with the DUT in IDLE.
  // clr_mode: 0 none, 1 during IDLE, 2 during EXEC, 3 during ACK.
  task automatic run_slot(input int clr_mode);
    int w;
    logic e;
    logic [NREQ-1:0] exp_ack;
    drive_req();
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j = (m_ptr + k) % NREQ;
      if (w < 0 && pend[j]) w = j;
    end
    last_w = w;
    clr = (clr_mode == 1);
    @(negedge clk);
    check_val("idle_busy", busy, 0);
    check_val("idle_ack", ack, 0);
    check_val("idle_count", count, stk.size());
    @(posedge clk); #1;
    if (clr_mode == 1) stk.delete();
    if (w < 0) begin
      clr = 1'b0;
      return;
    end
    clr = (clr_mode == 2);
    @(negedge clk);
    check_val("exec_gnt", gnt_id, w);
    check_val("exec_busy", busy, 1);
    check_val("exec_ack", ack, 0);
    @(posedge clk); #1;
    e = 1'b0;
    if (clr_mode == 2) begin
      e = 1'b1;
      stk.delete();
    end else if (!pop_r[w]) begin
      if (stk.size() < DEPTH) stk.push_back(dat_r[w]);
      else e = 1'b1;
    end else begin
      if (stk.size() > 0) m_rdata = stk.pop_back();
      else e = 1'b1;
    end
    m_ptr = (w + 1) % NREQ;
    clr = (clr_mode == 3);
    exp_ack = '0;
    exp_ack[w] = 1'b1;
    @(negedge clk);
    ack_cyc = cyc;
    check_val("ack", ack, exp_ack);
    check_val("err", err, e);
    if (pop_r[w] && clr_mode != 2) check_val("rdata", rdata, m_rdata);
    check_val("ack_count", count, stk.size());
    check_val("full", full, stk.size() == DEPTH);
    check_val("empty", empty, stk.size() == 0);
    @(posedge clk); #1;
    if (clr_mode == 3) stk.delete();
    clr = 1'b0;
    pend[w] = 1'b0;
    drive_req();
  endtask

  task automatic do_op(input int i, input logic is_pop, input logic [WIDTH-1:0] d, input int clr_mode);
    pend[i] = 1'b1; pop_r[i] = is_pop; dat_r[i] = d;
    run_slot(clr_mode);
  endtask

  initial begin
    int prev_cyc;
    rstn = 1'b0; clr = 1'b0; req = '0; op = '0; wdata = '0;
    last_w = -1; ack_cyc = 0;
    clear_pend();

    // Single push
    apply_reset();
    do_op(0, 1'b0, 4'hA, 0);

    // Push 1,2,3 then four pops; the last one underflows
    apply_reset();
    for (int v = 1; v <= 3; v++) do_op(1, 1'b0, WIDTH'(v), 0);
    for (int n = 0; n < 4; n++) do_op(2, 1'b1, '0, 0);
    check_val("underflow_rdata", rdata, 1);

    // Fill, overflow, pop top
    apply_reset();
    for (int v = 0; v < DEPTH; v++) do_op(v % NREQ, 1'b0, WIDTH'(v), 0);
    check_val("fill_full", full, 1);
    do_op(3, 1'b0, 4'hF, 0);
    check_val("ovf_count", count, DEPTH);
    do_op(0, 1'b1, '0, 0);
    check_val("ovf_pop", rdata, 7);

    // All requesters held continuously: strict rotation, 3 cycles apart
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1; pop_r[i] = 1'b0; dat_r[i] = WIDTH'(i);
    end
    prev_cyc = -1;
    for (int n = 0; n < 2*NREQ; n++) begin
      run_slot(0);
      check_val("rr_order", last_w, n % NREQ);
      if (prev_cyc >= 0) check_val("rr_spacing", ack_cyc - prev_cyc, 3);
      prev_cyc = ack_cyc;
      pend[last_w] = 1'b1; pop_r[last_w] = 1'b0; dat_r[last_w] = WIDTH'(last_w);
    end
    clear_pend(); drive_req();

    // Flush during EXEC of a push at count 5
    apply_reset();
    for (int v = 0; v < 5; v++) do_op(0, 1'b0, WIDTH'(v), 0);
    do_op(1, 1'b0, 4'h9, 2);
    check_val("clr_exec_empty", empty, 1);

    // Asynchronous reset in the middle of EXEC
    apply_reset();
    do_op(1, 1'b0, 4'h5, 0);
    pend[1] = 1'b1; pop_r[1] = 1'b0; dat_r[1] = 4'h6;
    drive_req();
    @(negedge clk);
    @(posedge clk); #1;
    #2 rstn = 1'b0;
    #1;
    check_val("arst_ack", ack, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_gnt", gnt_id, 0);
    check_val("arst_count", count, 0);
    check_val("arst_err", err, 0);
    check_val("arst_rdata", rdata, 0);
    stk.delete(); m_ptr = 0; m_rdata = '0;
    clear_pend(); drive_req();
    rstn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_val("arst_no_ack", ack, 0);
    end
    @(posedge clk); #1;
    pend[1] = 1'b1; dat_r[1] = 4'h1;
    pend[3] = 1'b1; dat_r[3] = 4'h3;
    run_slot(0);
    check_val("arst_first_grant", last_w, 1);
    clear_pend(); drive_req();

    // Randomized traffic with occasional flushes
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      int r;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          pop_r[i] = ($urandom_range(0, 9) < 4);
          dat_r[i] = WIDTH'($urandom);
        end
      end
      r = $urandom_range(0, 15);
      run_slot((r < 3) ? r + 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
